vga_pixel_fifo_pio: RTL and testbench

//  Parametrised successor to the single-register pixel output port. An Avalon-MM slave (s1) pushes
//  CPU-written pixels into an internal FIFO. The FIFO drains on a valid/ready stream toward the VGA

---
 rtl/vga_pio_pkg.sv | 23 ++
 rtl/vga_pixel_sync_fifo.sv | 75 +++++++
 rtl/vga_pixel_fifo_pio.sv | 148 ++++++++++++++
 tb/tb_vga_pixel_fifo_pio.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pio_pkg.sv
// Shared constants for the VGA pixel FIFO port: register map and bit positions
// of the STATUS and CONTROL words.
package vga_pio_pkg;

    // Word addresses on the s1 slave
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;
    localparam logic [1:0] REG_INFO    = 2'd3;

    // STATUS bit positions; bits [15:0] carry the FIFO level
    localparam int ST_EMPTY = 16;
    localparam int ST_FULL  = 17;
    localparam int ST_OVF   = 18;
    localparam int ST_IRQ   = 19;

    // CONTROL bit positions
    localparam int CT_EN      = 0;
    localparam int CT_FLUSH   = 1;
    localparam int CT_IRQEN   = 2;
    localparam int CT_THR_LSB = 8;

endpackage

// File: rtl/vga_pixel_sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is always visible
// on pop_data; flush empties the FIFO and wins over a same-cycle push or pop.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module vga_pixel_sync_fifo
    import vga_pio_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty,
    output logic              full,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push, do_pop;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LVL_W'(DEPTH));
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Qualify requests and compute next pointers/level; pointers wrap naturally
    always_comb begin
        do_pop   = pop & ~empty & ~flush;
        do_push  = push & (~full | do_pop) & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset because level gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/vga_pixel_fifo_pio.sv
// VGA pixel FIFO port: Avalon-MM slave pushes CPU pixels into a FIFO that
// drains on a valid/ready stream; out_port keeps the last consumed pixel.
// Optional low-watermark interrupt is built when VGA_PIXEL_FIFO_IRQ_EN is
// defined; otherwise irq is held 0 and the IRQ_EN/THRESH fields read 0.
module vga_pixel_fifo_pio
    import vga_pio_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] out_port,
    output logic              irq
);

    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              wr_en, data_wr, status_wr, ctrl_wr, flush;
    logic              pop_req, pop_eff, ovf_evt;
    logic              fifo_empty, fifo_full;
    logic [LVL_W-1:0]  fifo_level;
    logic              enable_q, enable_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] out_port_q, out_port_d;
    logic              irq_q, irq_d;
    logic              unused_wd;
`ifdef VGA_PIXEL_FIFO_IRQ_EN
    logic              irq_en_q, irq_en_d;
    logic [LVL_W-1:0]  thresh_q, thresh_d;
`endif

    assign wr_en     = chipselect & ~write_n;
    assign data_wr   = wr_en & (address == REG_DATA);
    assign status_wr = wr_en & (address == REG_STATUS);
    assign ctrl_wr   = wr_en & (address == REG_CONTROL);
    assign flush     = ctrl_wr & writedata[CT_FLUSH];

    assign pix_valid = ~fifo_empty & enable_q;
    assign pop_req   = pix_valid & pix_ready;
    assign pop_eff   = pop_req & ~flush;
    assign ovf_evt   = data_wr & fifo_full & ~pop_eff;

    assign out_port  = out_port_q;
    assign irq       = irq_q;
    assign unused_wd = ^writedata;

    vga_pixel_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (data_wr),
        .push_data (writedata[DATA_W-1:0]),
        .pop       (pop_req),
        .flush     (flush),
        .pop_data  (pix_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    // Next state for control fields, sticky overflow, out_port and irq
    always_comb begin
        enable_d   = enable_q;
        ovf_d      = ovf_q;
        out_port_d = out_port_q;
        irq_d      = 1'b0;
`ifdef VGA_PIXEL_FIFO_IRQ_EN
        irq_en_d   = irq_en_q;
        thresh_d   = thresh_q;
`endif
        if (ctrl_wr) begin
            enable_d = writedata[CT_EN];
`ifdef VGA_PIXEL_FIFO_IRQ_EN
            irq_en_d = writedata[CT_IRQEN];
            thresh_d = writedata[CT_THR_LSB +: LVL_W];
`endif
        end
        // A flush clears overflow; a new overflow beats a software clear
        if (flush)                               ovf_d = 1'b0;
        else if (ovf_evt)                        ovf_d = 1'b1;
        else if (status_wr && writedata[ST_OVF]) ovf_d = 1'b0;
        if (pop_eff) out_port_d = pix_data;
`ifdef VGA_PIXEL_FIFO_IRQ_EN
        irq_d = irq_en_q & enable_q & (fifo_level <= thresh_q);
`endif
    end

    // Control and flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q   <= 1'b1;
            ovf_q      <= 1'b0;
            out_port_q <= '0;
            irq_q      <= 1'b0;
`ifdef VGA_PIXEL_FIFO_IRQ_EN
            irq_en_q   <= 1'b0;
            thresh_q   <= '0;
`endif
        end else begin
            enable_q   <= enable_d;
            ovf_q      <= ovf_d;
            out_port_q <= out_port_d;
            irq_q      <= irq_d;
`ifdef VGA_PIXEL_FIFO_IRQ_EN
            irq_en_q   <= irq_en_d;
            thresh_q   <= thresh_d;
`endif
        end
    end

    // Side-effect-free read mux; FLUSH always reads back 0
    always_comb begin
        readdata = '0;
        case (address)
            REG_DATA: readdata[DATA_W-1:0] = out_port_q;
            REG_STATUS: begin
                readdata[LVL_W-1:0] = fifo_level;
                readdata[ST_EMPTY]  = fifo_empty;
                readdata[ST_FULL]   = fifo_full;
                readdata[ST_OVF]    = ovf_q;
                readdata[ST_IRQ]    = irq_q;
            end
            REG_CONTROL: begin
                readdata[CT_EN] = enable_q;
`ifdef VGA_PIXEL_FIFO_IRQ_EN
                readdata[CT_IRQEN]               = irq_en_q;
                readdata[CT_THR_LSB +: LVL_W]    = thresh_q;
`endif
            end
            default: begin
                readdata[15:0]  = 16'(DEPTH);
                readdata[23:16] = 8'(DATA_W);
            end
        endcase
    end

endmodule

// File: tb/tb_vga_pixel_fifo_pio.sv
// Directed bench for vga_pixel_fifo_pio (DATA_W=24, DEPTH=16). Inputs change
// on the falling edge; outputs are sampled on the falling edge after settling.
module tb_vga_pixel_fifo_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] out_port;
    logic        irq;

    int total = 0;
    int bad   = 0;

    vga_pixel_fifo_pio #(.DATA_W(24), .DEPTH(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; the write is taken on the next rising edge
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", pix_valid); end
        total++; if (out_port !== 24'h0) begin bad++; $display("FAIL rst_out_port got=%h exp=000000", out_port); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
        bus_read(2'd2, rd);
        total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL rst_control got=%h exp=00000001", rd); end
        bus_read(2'd3, rd);
        total++; if (rd !== 32'h0018_0010) begin bad++; $display("FAIL rst_info got=%h exp=00180010", rd); end
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h0001_0000) begin bad++; $display("FAIL rst_status got=%h exp=00010000", rd); end
    endtask

    task automatic test_single_pixel();
        logic [31:0] rd;
        pix_ready = 1'b1;
        bus_write(2'd0, 32'h00AA_BBCC);
        total++; if (pix_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", pix_valid); end
        total++; if (pix_data !== 24'hAABBCC) begin bad++; $display("FAIL single_data got=%h exp=aabbcc", pix_data); end
        @(negedge clk);
        total++; if (out_port !== 24'hAABBCC) begin bad++; $display("FAIL single_out_port got=%h exp=aabbcc", out_port); end
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b exp=0", pix_valid); end
        bus_read(2'd0, rd);
        total++; if (rd !== 32'h00AA_BBCC) begin bad++; $display("FAIL single_rd_data got=%h exp=00aabbcc", rd); end
        pix_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        pix_ready = 1'b0;
        for (int i = 1; i <= 17; i++) bus_write(2'd0, 32'(i));
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h0006_0010) begin bad++; $display("FAIL ovf_status got=%h exp=00060010", rd); end
        total++; if (pix_data !== 24'h000001) begin bad++; $display("FAIL ovf_head got=%h exp=000001", pix_data); end
        bus_write(2'd1, 32'h0004_0000);
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h0002_0010) begin bad++; $display("FAIL ovf_clear got=%h exp=00020010", rd); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] rd;
        logic [23:0] exp;
        pix_ready = 1'b1;
        bus_write(2'd0, 32'h0012_3456);
        pix_ready = 1'b0;
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h0002_0010) begin bad++; $display("FAIL fpp_status got=%h exp=00020010", rd); end
        total++; if (out_port !== 24'h000001) begin bad++; $display("FAIL fpp_out_port got=%h exp=000001", out_port); end
        pix_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp = (k < 15) ? 24'(k + 2) : 24'h123456;
            total++; if (pix_data !== exp) begin bad++; $display("FAIL drain_%0d got=%h exp=%h", k, pix_data, exp); end
            @(negedge clk);
        end
        pix_ready = 1'b0;
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", pix_valid); end
        total++; if (out_port !== 24'h123456) begin bad++; $display("FAIL drain_last got=%h exp=123456", out_port); end
    endtask

    task automatic test_flush_enable();
        logic [31:0] rd;
        pix_ready = 1'b0;
        for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h50 + 32'(i));
        pix_ready = 1'b1;
        bus_write(2'd2, 32'h0000_0002);
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h0001_0000) begin bad++; $display("FAIL flush_status got=%h exp=00010000", rd); end
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", pix_valid); end
        total++; if (out_port !== 24'h123456) begin bad++; $display("FAIL flush_out_port got=%h exp=123456", out_port); end
        bus_read(2'd2, rd);
        total++; if (rd !== 32'h0000_0000) begin bad++; $display("FAIL flush_control got=%h exp=00000000", rd); end
        bus_write(2'd0, 32'h0077_7777);
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL stall_status got=%h exp=00000001", rd); end
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL stall_valid got=%b exp=0", pix_valid); end
        bus_write(2'd2, 32'h0000_0001);
        total++; if (pix_valid !== 1'b1) begin bad++; $display("FAIL resume_valid got=%b exp=1", pix_valid); end
        total++; if (pix_data !== 24'h777777) begin bad++; $display("FAIL resume_data got=%h exp=777777", pix_data); end
        @(negedge clk);
        pix_ready = 1'b0;
        total++; if (out_port !== 24'h777777) begin bad++; $display("FAIL resume_out_port got=%h exp=777777", out_port); end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        pix_ready = 1'b0;
        for (int i = 1; i <= 6; i++) bus_write(2'd0, 32'h0060_0000 + 32'(i));
        bus_write(2'd2, 32'h0000_0405);
        bus_read(2'd2, rd);
`ifdef VGA_PIXEL_FIFO_IRQ_EN
        total++; if (rd !== 32'h0000_0405) begin bad++; $display("FAIL irq_control got=%h exp=00000405", rd); end
`else
        total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL irq_control got=%h exp=00000001", rd); end
`endif
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_at6 got=%b exp=0", irq); end
        pix_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pix_ready = 1'b0;
        total++; if (out_port !== 24'h600002) begin bad++; $display("FAIL irq_out_port got=%h exp=600002", out_port); end
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h0000_0004) begin bad++; $display("FAIL irq_lvl4_status got=%h exp=00000004", rd); end
        @(negedge clk);
        bus_read(2'd1, rd);
`ifdef VGA_PIXEL_FIFO_IRQ_EN
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", irq); end
        total++; if (rd !== 32'h0008_0004) begin bad++; $display("FAIL irq_set_status got=%h exp=00080004", rd); end
`else
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_set got=%b exp=0", irq); end
        total++; if (rd !== 32'h0000_0004) begin bad++; $display("FAIL irq_set_status got=%h exp=00000004", rd); end
`endif
        bus_write(2'd0, 32'h0000_00A1);
        bus_write(2'd0, 32'h0000_00A2);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", irq); end
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h0000_0006) begin bad++; $display("FAIL irq_clear_status got=%h exp=00000006", rd); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] rd;
        pix_ready = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", pix_valid); end
        total++; if (out_port !== 24'h0) begin bad++; $display("FAIL mid_out_port got=%h exp=000000", out_port); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq got=%b exp=0", irq); end
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h0001_0000) begin bad++; $display("FAIL mid_status got=%h exp=00010000", rd); end
        bus_read(2'd2, rd);
        total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL mid_control got=%h exp=00000001", rd); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (out_port !== 24'h0) begin bad++; $display("FAIL post_out_port got=%h exp=000000", out_port); end
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL post_valid got=%b exp=0", pix_valid); end
        pix_ready = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        pix_ready  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_pixel();
        test_overflow();
        test_full_push_pop();
        test_flush_enable();
        test_irq();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
